// File: rtl/var_scan_sequencer_if.sv
// Host-side and generator-side signal bundle for one variable-scan channel.
// Latency: n/a (wiring only).
// Backpressure: none; the master drives requests, the slave drives status and generator controls.
interface var_scan_sequencer_if #(
  parameter int STEP_W = 16
);
  logic              cfg_we;
  logic [2:0]        cfg_addr;
  logic [15:0]       cfg_data;
  logic              start;
  logic              abort;
  logic              pause;
  logic [15:0]       scan_min;
  logic [15:0]       scan_max;
  logic [15:0]       increment;
  logic              sinit;
  logic              scan_enable;
  logic              scan_advance_ce;
  logic              busy;
  logic              done;
  logic [STEP_W-1:0] steps_done;

  modport master (
    output cfg_we, cfg_addr, cfg_data, start, abort, pause,
    input  scan_min, scan_max, increment, sinit, scan_enable,
           scan_advance_ce, busy, done, steps_done
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, start, abort, pause,
    output scan_min, scan_max, increment, sinit, scan_enable,
           scan_advance_ce, busy, done, steps_done
  );
endinterface

// File: rtl/var_scan_sequencer.sv
// Holds scan config, issues generator init, paces dwell-spaced step strobes, reports completion.
// Latency: sinit 1 cycle after accepted start, scan_enable 6 cycles after, done 1 cycle after last strobe.
// Backpressure: none; start while busy is ignored, config writes while busy are dropped.
module var_scan_sequencer #(
  parameter int DWELL_W = 16,
  parameter int STEP_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  var_scan_sequencer_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_INIT = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // INIT spans init_cnt 0..4; the first of those cycles carries sinit.
  localparam logic [2:0] INIT_LAST = 3'd4;

  typedef struct packed {
    logic [15:0]        scan_min;
    logic [15:0]        scan_max;
    logic [15:0]        increment;
    logic [DWELL_W-1:0] dwell;
    logic [STEP_W-1:0]  step_count;
  } cfg_t;

  cfg_t               cfg_q, cfg_d;
  logic [1:0]         state_q, state_d;
  logic [2:0]         init_cnt_q, init_cnt_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [STEP_W-1:0]  steps_q, steps_d;
  logic [15:0]        min_q, min_d;
  logic [15:0]        max_q, max_d;
  logic [15:0]        inc_q, inc_d;
  logic               sinit_q, sinit_d;
  logic               en_q, en_d;
  logic               adv_q, adv_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [DWELL_W-1:0] dwell_m1;

  // Dwell reload value; a dwell of 0 behaves as 1 (strobe every non-paused cycle).
  always_comb begin
    dwell_m1 = '0;
    if (cfg_q.dwell != '0) dwell_m1 = cfg_q.dwell - DWELL_W'(1);
  end

  // Host config writes, accepted only while the channel is idle.
  always_comb begin
    cfg_d = cfg_q;
    if (bus.cfg_we && !busy_q) begin
      case (bus.cfg_addr)
        3'd0:    cfg_d.scan_min   = bus.cfg_data;
        3'd1:    cfg_d.scan_max   = bus.cfg_data;
        3'd2:    cfg_d.increment  = bus.cfg_data;
        3'd3:    cfg_d.dwell      = bus.cfg_data[DWELL_W-1:0];
        3'd4:    cfg_d.step_count = bus.cfg_data[STEP_W-1:0];
        default: ;
      endcase
    end
  end

  // Sequencer FSM, dwell pacing and step counting. Outputs are computed for the
  // next cycle so every output comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    dwell_cnt_d = dwell_cnt_q;
    steps_d     = steps_q;
    min_d       = min_q;
    max_d       = max_q;
    inc_d       = inc_q;
    adv_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d    = S_INIT;
          init_cnt_d = '0;
          steps_d    = '0;
          min_d      = cfg_q.scan_min;
          max_d      = cfg_q.scan_max;
          inc_d      = cfg_q.increment;
        end
      end
      S_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          if (cfg_q.step_count == '0) begin
            state_d = S_DONE;
          end else begin
            state_d     = S_RUN;
            dwell_cnt_d = dwell_m1;
            // With dwell <= 1 the first RUN cycle already strobes.
            if (dwell_m1 == '0) begin
              adv_d   = 1'b1;
              steps_d = steps_q + STEP_W'(1);
            end
          end
        end else begin
          init_cnt_d = init_cnt_q + 3'd1;
        end
      end
      S_RUN: begin
        if (steps_q == cfg_q.step_count) begin
          state_d = S_DONE;
        end else if (!bus.pause) begin
          // Counter sits at 0 only in the cycle its strobe went out, so reload there.
          if (dwell_cnt_q == '0) dwell_cnt_d = dwell_m1;
          else                   dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
          if (dwell_cnt_d == '0) begin
            adv_d   = 1'b1;
            steps_d = steps_q + STEP_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort from any active state: drop to IDLE, suppress the strobe, keep the step count.
    if (state_q != S_IDLE && bus.abort) begin
      state_d = S_IDLE;
      adv_d   = 1'b0;
      steps_d = steps_q;
    end

    sinit_d = (state_q == S_IDLE) && (state_d == S_INIT);
    en_d    = (state_d == S_RUN);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q       <= '0;
      state_q     <= S_IDLE;
      init_cnt_q  <= '0;
      dwell_cnt_q <= '0;
      steps_q     <= '0;
      min_q       <= '0;
      max_q       <= '0;
      inc_q       <= '0;
      sinit_q     <= 1'b0;
      en_q        <= 1'b0;
      adv_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      cfg_q       <= cfg_d;
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      dwell_cnt_q <= dwell_cnt_d;
      steps_q     <= steps_d;
      min_q       <= min_d;
      max_q       <= max_d;
      inc_q       <= inc_d;
      sinit_q     <= sinit_d;
      en_q        <= en_d;
      adv_q       <= adv_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.scan_min        = min_q;
  assign bus.scan_max        = max_q;
  assign bus.increment       = inc_q;
  assign bus.sinit           = sinit_q;
  assign bus.scan_enable     = en_q;
  assign bus.scan_advance_ce = adv_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.steps_done      = steps_q;

endmodule

// File: tb/tb_var_scan_sequencer.sv
// Directed bench for var_scan_sequencer: table of full runs plus hand sequences.
// Cycle k below is the k-th clock period after the edge that samples start.
// Inputs change and outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_var_scan_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  var_scan_sequencer_if #(.STEP_W(16)) bus ();

  var_scan_sequencer #(.DWELL_W(16), .STEP_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] mn, mx, inc, dw, st;
    int pause_lo, pause_hi;  // cycles with pause driven high (0,0 = none)
    int abort_at;            // cycle with abort driven high (0 = none)
    int wr_at;               // cycle with a stray write to addr 1 (0 = none)
    int first, sp, n;        // strobe cycles: first, first+sp, ... (n of them)
    int done_at;             // cycle with done (0 = none)
    int busy_end;            // last cycle with busy
    int en_end;              // last cycle with scan_enable (enable starts at 6)
    int steps_exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic adv_exp(input vec_t v, input int k);
    if (v.n == 0 || k < v.first) return 1'b0;
    return ((k - v.first) % v.sp == 0) && ((k - v.first) / v.sp < v.n);
  endfunction

  task automatic cfg_write(input logic [2:0] a, input logic [15:0] d);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_data = d;
    @(negedge clk);
    bus.cfg_we   = 1'b0;
  endtask

  // Returns in cycle 1 of the run.
  task automatic start_pulse();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [4:0] got, exp;
    cfg_write(3'd0, v.mn);
    cfg_write(3'd1, v.mx);
    cfg_write(3'd2, v.inc);
    cfg_write(3'd3, v.dw);
    cfg_write(3'd4, v.st);
    start_pulse();
    for (int k = 1; k <= v.busy_end + 2; k++) begin
      exp = {k == 1, k <= v.busy_end, k == v.done_at, (k >= 6) && (k <= v.en_end), adv_exp(v, k)};
      got = {bus.sinit, bus.busy, bus.done, bus.scan_enable, bus.scan_advance_ce};
      check($sformatf("vec%0d cyc%0d {sinit,busy,done,en,adv}", idx, k), 64'(got), 64'(exp));
      bus.pause = (k >= v.pause_lo) && (k <= v.pause_hi);
      bus.abort = (k == v.abort_at);
      if (k == v.wr_at) begin
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 3'd1;
        bus.cfg_data = 16'h7777;
      end else begin
        bus.cfg_we = 1'b0;
      end
      @(negedge clk);
    end
    bus.pause  = 1'b0;
    bus.abort  = 1'b0;
    bus.cfg_we = 1'b0;
    check($sformatf("vec%0d steps_done", idx), 64'(bus.steps_done), 64'(v.steps_exp));
    check($sformatf("vec%0d shadows", idx), {16'h0, bus.scan_min, bus.scan_max, bus.increment},
          {16'h0, v.mn, v.mx, v.inc});
  endtask

  vec_t vecs [6];

  initial begin
    // Expected strobe/done cycles hand-computed: first strobe at 6+dwell-1
    // (dwell 0 as 1), spacing dwell non-paused cycles, done one cycle after the last.
    vecs[0] = '{mn:16'h0010, mx:16'h0100, inc:16'h0080, dw:16'd4, st:16'd5,
                pause_lo:0, pause_hi:0, abort_at:0, wr_at:0,
                first:9, sp:4, n:5, done_at:26, busy_end:26, en_end:25, steps_exp:5};
    vecs[1] = '{mn:16'h1111, mx:16'h2222, inc:16'h0001, dw:16'd0, st:16'd3,
                pause_lo:0, pause_hi:0, abort_at:0, wr_at:0,
                first:6, sp:1, n:3, done_at:9, busy_end:9, en_end:8, steps_exp:3};
    vecs[2] = '{mn:16'h0005, mx:16'h0006, inc:16'h0007, dw:16'd7, st:16'd0,
                pause_lo:0, pause_hi:0, abort_at:0, wr_at:0,
                first:0, sp:1, n:0, done_at:6, busy_end:6, en_end:5, steps_exp:0};
    // pause high during cycles 8..14 (2 cycles into RUN, 7 cycles long).
    vecs[3] = '{mn:16'h0100, mx:16'h0F00, inc:16'h0010, dw:16'd5, st:16'd4,
                pause_lo:8, pause_hi:14, abort_at:0, wr_at:0,
                first:17, sp:5, n:4, done_at:33, busy_end:33, en_end:32, steps_exp:4};
    vecs[4] = '{mn:16'h0003, mx:16'h0004, inc:16'h0001, dw:16'd1, st:16'd2,
                pause_lo:0, pause_hi:0, abort_at:0, wr_at:0,
                first:6, sp:1, n:2, done_at:8, busy_end:8, en_end:7, steps_exp:2};
    // Abort presented in cycle 8 is sampled by the edge that would launch the
    // 2nd strobe (cycle 9), so cycle 9 is already IDLE with no strobe.
    // The write to addr 1 in cycle 3 lands while busy and must be dropped.
    vecs[5] = '{mn:16'h0001, mx:16'h0200, inc:16'h0003, dw:16'd2, st:16'd6,
                pause_lo:0, pause_hi:0, abort_at:8, wr_at:3,
                first:7, sp:2, n:1, done_at:0, busy_end:8, en_end:8, steps_exp:1};

    rst = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_addr = 3'd0; bus.cfg_data = 16'h0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.pause = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset status", 64'({bus.sinit, bus.busy, bus.done, bus.scan_enable, bus.scan_advance_ce, bus.steps_done}), 64'h0);
    check("reset shadows", 64'({bus.scan_min, bus.scan_max, bus.increment}), 64'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Write during the aborted run was dropped: scan_max still 0x0200 on a new start.
    cfg_write(3'd4, 16'd0);
    start_pulse();
    check("dropped write scan_max", 64'(bus.scan_max), 64'h0200);
    for (int k = 0; k < 7; k++) @(negedge clk);
    // Idle write is accepted.
    cfg_write(3'd1, 16'h5555);
    start_pulse();
    check("idle write scan_max", 64'(bus.scan_max), 64'h5555);
    for (int k = 0; k < 7; k++) @(negedge clk);

    // start together with abort in IDLE: nothing happens.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      check($sformatf("start+abort cyc%0d {sinit,busy,en,done}", k),
            64'({bus.sinit, bus.busy, bus.scan_enable, bus.done}), 64'h0);
      @(negedge clk);
    end

    // Reset mid-RUN after 4 strobes (dwell 3: strobes at 8, 11, 14, 17).
    cfg_write(3'd0, 16'h0011);
    cfg_write(3'd1, 16'h0022);
    cfg_write(3'd2, 16'h0033);
    cfg_write(3'd3, 16'd3);
    cfg_write(3'd4, 16'd10);
    start_pulse();
    for (int k = 1; k < 18; k++) @(negedge clk);
    check("midrun steps_done", 64'(bus.steps_done), 64'd4);
    check("midrun scan_enable", 64'(bus.scan_enable), 64'd1);
    rst = 1'b1;
    #1;
    check("async reset status", 64'({bus.sinit, bus.busy, bus.done, bus.scan_enable, bus.scan_advance_ce, bus.steps_done}), 64'h0);
    check("async reset shadows", 64'({bus.scan_min, bus.scan_max, bus.increment}), 64'h0);
    @(negedge clk);
    @(negedge clk);
    check("held reset status", 64'({bus.busy, bus.scan_enable, bus.scan_advance_ce, bus.steps_done}), 64'h0);
    rst = 1'b0;
    @(negedge clk);
    check("post reset busy", 64'(bus.busy), 64'd0);
    // Config was cleared: readback run has zero shadows and step_count 0 (done at cycle 6).
    start_pulse();
    check("readback shadows", 64'({bus.scan_min, bus.scan_max, bus.increment}), 64'h0);
    check("readback busy/sinit", 64'({bus.busy, bus.sinit}), 64'h3);
    for (int k = 1; k <= 7; k++) begin
      check($sformatf("readback cyc%0d {done,en,adv}", k),
            64'({bus.done, bus.scan_enable, bus.scan_advance_ce}), (k == 6) ? 64'h4 : 64'h0);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
